// File: rtl/mmio_responder.sv
// mmio_responder: CPU-mapped LED/switch/status block at 0x300, debounced switches, optional timer (MMIO_RESPONDER_TIMER_EN).
module mmio_responder #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wdata,
  input  logic [9:0]       switches,
  output logic [WIDTH-1:0] rdata,
  output logic [9:0]       LEDs,
  output logic             irq
);
  logic             sel, wr, rd;
  logic [7:0]       off;
  logic [9:0]       sync1_q, sync2_q, sw_q, sw_d, led_q, led_d;
  logic [15:0]      db_q, db_d;
  logic             sc_q, sc_d, te_q, sw_evt;
  logic [WIDTH-1:0] rdata_q, rdata_d, cmp_q, tcnt_q, rd_val;

  assign sel = addr[9:8] == 2'b11;
  assign off = addr[7:0];
  assign wr  = sel && we;
  assign rd  = sel && re && !we;

  // Counter runs only while the synchronized value disagrees with SW; any agreement restarts qualification.
  always_comb begin
    sw_evt = 1'b0;
    sw_d   = sw_q;
    db_d   = 16'd0;
    if (sync2_q != sw_q) begin
      if (db_q == 16'(DEBOUNCE_CYCLES - 1)) begin
        sw_d   = sync2_q;
        sw_evt = 1'b1;
      end else db_d = db_q + 16'd1;
    end
  end

  assign rd_val  = off == 8'h00 ? WIDTH'(led_q) :
                   off == 8'h01 ? WIDTH'(sw_q) :
                   off == 8'h02 ? WIDTH'({te_q, sc_q}) :
                   off == 8'h03 ? cmp_q :
                   off == 8'h04 ? tcnt_q : '0;
  assign rdata_d = rd ? rd_val : rdata_q;
  assign led_d   = (wr && off == 8'h00) ? wdata[9:0] : led_q;
  assign sc_d    = sw_evt | (sc_q & ~(rd && off == 8'h02));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      db_q    <= '0;
      led_q   <= '0;
      sc_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      sync1_q <= switches;
      sync2_q <= sync1_q;
      sw_q    <= sw_d;
      db_q    <= db_d;
      led_q   <= led_d;
      sc_q    <= sc_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MMIO_RESPONDER_TIMER_EN
  logic [WIDTH-1:0] cmp_d, tcnt_d;
  logic             te_d, tmr_evt;
  assign tmr_evt = (cmp_q != '0) && (tcnt_q == cmp_q);
  assign cmp_d   = (wr && off == 8'h03) ? wdata : cmp_q;
  assign tcnt_d  = ((wr && off == 8'h03) || cmp_q == '0 || tmr_evt) ? '0 : tcnt_q + WIDTH'(1);
  assign te_d    = tmr_evt | (te_q & ~(wr && off == 8'h02 && wdata[1]));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_q  <= '0;
      tcnt_q <= '0;
      te_q   <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      tcnt_q <= tcnt_d;
      te_q   <= te_d;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata[WIDTH-1:10];
  assign cmp_q        = '0;
  assign tcnt_q       = '0;
  assign te_q         = 1'b0;
`endif

  assign rdata = rdata_q;
  assign LEDs  = led_q;
  assign irq   = sc_q | te_q;
endmodule
